// File: rtl/xip_cache_pkg.sv
// xip_cache_pkg: shared FSM states, default address windows and cache geometry helpers
package xip_cache_pkg;
    typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;
    localparam logic [31:0] FLASH_BASE_DEF = 32'h3000_0000;
    localparam logic [31:0] FLASH_END_DEF  = 32'h3fff_ffff;
    localparam logic [31:0] SPI_BASE_DEF   = 32'h1000_1000;
    localparam logic [31:0] SPI_END_DEF    = 32'h1000_1fff;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int tag_w(input int depth);
        return 26 - $clog2(depth);
    endfunction
endpackage

// File: rtl/xip_tag_array.sv
// xip_tag_array: direct-mapped valid/tag/data store; ports: clock/reset, flush_all (beats write), write port (we/widx/wtag/wdata), combinational lookup (ridx/rtag -> hit/rdata)
module xip_tag_array #(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4,
    parameter int TAGW  = 22
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_flush_all,
    input  logic            i_we,
    input  logic [IDXW-1:0] i_widx,
    input  logic [TAGW-1:0] i_wtag,
    input  logic [31:0]     i_wdata,
    input  logic [IDXW-1:0] i_ridx,
    input  logic [TAGW-1:0] i_rtag,
    output logic            o_hit,
    output logic [31:0]     o_rdata
);
    logic [DEPTH-1:0] r_valid;
    logic [TAGW-1:0]  r_tag  [DEPTH];
    logic [31:0]      r_data [DEPTH];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_valid <= '0;
        else if (i_flush_all) r_valid <= '0;
        else if (i_we) r_valid[i_widx] <= 1'b1;
    end
    // tag/data need no reset: they are qualified by valid
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end
    assign o_hit   = r_valid[i_ridx] && (r_tag[i_ridx] == i_rtag);
    assign o_rdata = r_data[i_ridx];
endmodule

// File: rtl/xip_read_cache_apb.sv
// xip_read_cache_apb: APB read cache in front of the SPI bridge; s_* upstream slave, m_* downstream master, flush invalidates all, hit_cnt/miss_cnt statistics
module xip_read_cache_apb
    import xip_cache_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = FLASH_BASE_DEF,
    parameter logic [31:0] FLASH_END  = FLASH_END_DEF,
    parameter logic [31:0] SPI_BASE   = SPI_BASE_DEF,
    parameter logic [31:0] SPI_END    = SPI_END_DEF,
    parameter int          DEPTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_paddr,
    input  logic        s_psel,
    input  logic        s_penable,
    input  logic        s_pwrite,
    input  logic [2:0]  s_pprot,
    input  logic [31:0] s_pwdata,
    input  logic [3:0]  s_pstrb,
    output logic        s_pready,
    output logic [31:0] s_prdata,
    output logic        s_pslverr,
    output logic [31:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [2:0]  m_pprot,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    input  logic        m_pready,
    input  logic [31:0] m_prdata,
    input  logic        m_pslverr,
    input  logic        flush,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDXW = idx_w(DEPTH);
    localparam int TAGW = tag_w(DEPTH);
    state_t          r_state, w_next;
    logic [31:0]     r_paddr, r_pwdata, r_rdata, r_hit_cnt, r_miss_cnt;
    logic [3:0]      r_pstrb;
    logic [2:0]      r_pprot;
    logic            r_pwrite, r_fill, r_slverr;
    logic [IDXW-1:0] r_idx, w_idx;
    logic [TAGW-1:0] r_tag, w_tag;
    logic [31:0]     w_lu_data;
    logic            w_lu_hit, w_req, w_flash, w_hit, w_miss, w_done, w_spi_wr, w_we;
    assign w_req    = (r_state == IDLE) && s_psel && s_penable;
    assign w_flash  = (s_paddr >= FLASH_BASE) && (s_paddr <= FLASH_END);
    assign w_idx    = s_paddr[IDXW+1:2];
    assign w_tag    = s_paddr[27:IDXW+2];
    assign w_hit    = w_req && w_flash && !s_pwrite && w_lu_hit;
    assign w_miss   = w_req && w_flash && !s_pwrite && !w_lu_hit;
    assign w_done   = (r_state == M_ACCESS) && m_pready;
    // flash config may change on any write into the SPI master window
    assign w_spi_wr = w_done && r_pwrite && (r_paddr >= SPI_BASE) && (r_paddr <= SPI_END);
    assign w_we     = w_done && r_fill && !m_pslverr;
    xip_tag_array #(.DEPTH(DEPTH), .IDXW(IDXW), .TAGW(TAGW)) u_tags (
        .clock       (clock),
        .reset       (reset),
        .i_flush_all (flush || w_spi_wr),
        .i_we        (w_we),
        .i_widx      (r_idx),
        .i_wtag      (r_tag),
        .i_wdata     (m_prdata),
        .i_ridx      (w_idx),
        .i_rtag      (w_tag),
        .o_hit       (w_lu_hit),
        .o_rdata     (w_lu_data)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // hits and flash writes answer locally; everything else goes downstream
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)     ? (w_req ? ((w_flash && (s_pwrite || w_lu_hit)) ? RESP : M_SETUP) : IDLE) :
                 (r_state == M_SETUP)  ? M_ACCESS :
                 (r_state == M_ACCESS) ? (m_pready ? RESP : M_ACCESS) : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_pprot    <= '0;
            r_pwrite   <= 1'b0;
            r_fill     <= 1'b0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_rdata    <= '0;
            r_slverr   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_req) begin
                r_paddr  <= w_flash ? {s_paddr[31:2], 2'b00} : s_paddr;
                r_pwrite <= w_flash ? 1'b0 : s_pwrite;
                r_pstrb  <= w_flash ? 4'hf : s_pstrb;
                r_pwdata <= s_pwdata;
                r_pprot  <= s_pprot;
                r_fill   <= w_flash && !s_pwrite;
                r_idx    <= w_idx;
                r_tag    <= w_tag;
                r_rdata  <= w_hit ? w_lu_data : '0;
                r_slverr <= w_flash && s_pwrite;
            end
            if (w_done) begin
                r_rdata  <= m_prdata;
                r_slverr <= m_pslverr;
            end
            r_hit_cnt  <= r_hit_cnt + {31'b0, w_hit};
            r_miss_cnt <= r_miss_cnt + {31'b0, w_miss};
        end
    end
    assign s_pready  = (r_state == RESP);
    assign s_prdata  = (r_state == RESP) ? r_rdata : '0;
    assign s_pslverr = (r_state == RESP) && r_slverr;
    assign m_psel    = (r_state == M_SETUP) || (r_state == M_ACCESS);
    assign m_penable = (r_state == M_ACCESS);
    assign m_paddr   = r_paddr;
    assign m_pwrite  = r_pwrite;
    assign m_pwdata  = r_pwdata;
    assign m_pstrb   = r_pstrb;
    assign m_pprot   = r_pprot;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_xip_read_cache_apb.sv
// tb_xip_read_cache_apb: directed scoreboard bench for xip_read_cache_apb with a behavioural downstream APB slave
module tb_xip_read_cache_apb;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] s_paddr, s_pwdata, s_prdata, m_paddr, m_pwdata, hit_cnt, miss_cnt;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [2:0]  s_pprot, m_pprot;
    logic [3:0]  s_pstrb, m_pstrb;
    logic        m_psel, m_penable, m_pwrite;
    logic        m_pready = 1'b0;
    logic [31:0] m_prdata = '0;
    logic        m_pslverr = 1'b0;
    logic        flush = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] sb[$];
    int          ds_lat = 0, ds_w = 0, ds_setups = 0;
    logic        ds_err = 1'b0, flush_req = 1'b0, flush_on_fill = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic        last_write = 1'b0;
    logic [3:0]  last_strb = '0;
    logic [2:0]  last_prot = '0;

    xip_read_cache_apb dut (
        .clock(clock), .reset(reset),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pprot(s_pprot), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_pprot(m_pprot), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    // downstream slave: answers ds_lat cycles into the access phase; can pulse flush on the fill edge
    always @(negedge clock) begin
        flush = flush_req;
        if (m_psel && !m_penable) begin
            ds_setups++;
            last_addr = m_paddr; last_write = m_pwrite; last_wdata = m_pwdata;
            last_strb = m_pstrb; last_prot = m_pprot;
        end
        if (m_psel && m_penable && !m_pready) begin
            if (ds_w >= ds_lat) begin
                m_pready = 1'b1; m_prdata = mem_data; m_pslverr = ds_err;
                if (flush_on_fill) flush = 1'b1;
            end else ds_w++;
        end else begin
            m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0; ds_w = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] st, input logic fl, input logic [31:0] ed, input logic ee,
                        output int lat);
        logic [32:0] e;
        logic got;
        sb.push_back({ee, ed});
        s_paddr = a; s_pwrite = w; s_pwdata = d; s_pstrb = st; s_pprot = 3'b010;
        s_psel = 1'b1; s_penable = 1'b0;
        @(posedge clock); #1 s_penable = 1'b1;
        if (fl) flush_req = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clock); #1;
            flush_req = 1'b0;
            lat++;
            got = s_pready;
        end
        e = sb.pop_front();
        chk({tag, " ready"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " rdata"}, s_prdata, e[31:0]);
            chk({tag, " slverr"}, 32'(s_pslverr), 32'(e[32]));
        end
        s_psel = 1'b0; s_penable = 1'b0;
        @(posedge clock); #1;
        chk({tag, " ready drop"}, 32'(s_pready), 32'd0);
    endtask

    initial begin
        int s0, lat, n;
        reset = 1'b1;
        s_paddr = '0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_pprot = '0; s_pwdata = '0; s_pstrb = '0;
        #1;
        chk("rst ready", 32'(s_pready), 32'd0);
        chk("rst psel", 32'(m_psel), 32'd0);
        chk("rst paddr", m_paddr, 32'd0);
        chk("rst hit", hit_cnt, 32'd0);
        chk("rst miss", miss_cnt, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        mem_data = 32'hdeadbeef; s0 = ds_setups;
        xfer("miss1", 32'h30000010, 1'b0, 32'h0, 4'h3, 1'b0, 32'hdeadbeef, 1'b0, lat);
        chk("miss1 setups", 32'(ds_setups - s0), 32'd1);
        chk("miss1 addr", last_addr, 32'h30000010);
        chk("miss1 strb", 32'(last_strb), 32'hf);
        chk("miss1 write", 32'(last_write), 32'd0);
        chk("miss1 prot", 32'(last_prot), 32'd2);
        chk("miss1 cnt", miss_cnt, 32'd1);

        mem_data = 32'h11111111; s0 = ds_setups;
        xfer("hit1", 32'h30000013, 1'b0, 32'h0, 4'h0, 1'b0, 32'hdeadbeef, 1'b0, lat);
        chk("hit1 setups", 32'(ds_setups - s0), 32'd0);
        chk("hit1 lat", 32'(lat), 32'd1);
        chk("hit1 cnt", hit_cnt, 32'd1);

        mem_data = 32'h55555555;
        xfer("conf1", 32'h30000050, 1'b0, 32'h0, 4'hf, 1'b0, 32'h55555555, 1'b0, lat);
        mem_data = 32'h66666666;
        xfer("conf2", 32'h30000010, 1'b0, 32'h0, 4'hf, 1'b0, 32'h66666666, 1'b0, lat);
        chk("conf miss cnt", miss_cnt, 32'd3);
        mem_data = 32'h0;
        xfer("conf hit", 32'h30000010, 1'b0, 32'h0, 4'hf, 1'b0, 32'h66666666, 1'b0, lat);
        chk("conf hit cnt", hit_cnt, 32'd2);

        mem_data = 32'h77777777;
        xfer("fill20", 32'h30000020, 1'b0, 32'h0, 4'hf, 1'b0, 32'h77777777, 1'b0, lat);
        mem_data = 32'h0;
        xfer("hit20", 32'h30000020, 1'b0, 32'h0, 4'hf, 1'b0, 32'h77777777, 1'b0, lat);

        mem_data = 32'h0000abcd; s0 = ds_setups;
        xfer("pt wr", 32'h20000000, 1'b1, 32'hcafef00d, 4'h2, 1'b0, 32'h0000abcd, 1'b0, lat);
        chk("pt wr setups", 32'(ds_setups - s0), 32'd1);
        chk("pt wr addr", last_addr, 32'h20000000);
        mem_data = 32'h0;
        xfer("pt keep", 32'h30000020, 1'b0, 32'h0, 4'hf, 1'b0, 32'h77777777, 1'b0, lat);
        chk("pt hit cnt", hit_cnt, 32'd4);
        chk("pt miss cnt", miss_cnt, 32'd4);

        xfer("spi wr", 32'h10001004, 1'b1, 32'h03000000, 4'h5, 1'b0, 32'h0, 1'b0, lat);
        chk("spi wr write", 32'(last_write), 32'd1);
        chk("spi wr data", last_wdata, 32'h03000000);
        chk("spi wr strb", 32'(last_strb), 32'h5);
        chk("spi wr addr", last_addr, 32'h10001004);
        mem_data = 32'h88888888;
        xfer("post spi", 32'h30000020, 1'b0, 32'h0, 4'hf, 1'b0, 32'h88888888, 1'b0, lat);
        chk("post spi miss", miss_cnt, 32'd5);

        s0 = ds_setups;
        xfer("fl wr", 32'h30000000, 1'b1, 32'h12345678, 4'hf, 1'b0, 32'h0, 1'b1, lat);
        chk("fl wr setups", 32'(ds_setups - s0), 32'd0);
        chk("fl wr hit", hit_cnt, 32'd4);
        chk("fl wr miss", miss_cnt, 32'd5);

        ds_err = 1'b1; mem_data = 32'hbad0bad0;
        xfer("err rd", 32'h30000030, 1'b0, 32'h0, 4'hf, 1'b0, 32'hbad0bad0, 1'b1, lat);
        ds_err = 1'b0; mem_data = 32'h12345678;
        xfer("after err", 32'h30000030, 1'b0, 32'h0, 4'hf, 1'b0, 32'h12345678, 1'b0, lat);
        chk("after err miss", miss_cnt, 32'd7);
        mem_data = 32'h0;
        xfer("hit30", 32'h30000030, 1'b0, 32'h0, 4'hf, 1'b0, 32'h12345678, 1'b0, lat);
        chk("hit30 cnt", hit_cnt, 32'd5);

        flush_req = 1'b1;
        @(posedge clock); #1 flush_req = 1'b0;
        @(posedge clock); #1;
        mem_data = 32'h99999999;
        xfer("post flush", 32'h30000030, 1'b0, 32'h0, 4'hf, 1'b0, 32'h99999999, 1'b0, lat);
        chk("post flush miss", miss_cnt, 32'd8);

        flush_on_fill = 1'b1; mem_data = 32'haaaaaaaa;
        xfer("fill+flush", 32'h30000040, 1'b0, 32'h0, 4'hf, 1'b0, 32'haaaaaaaa, 1'b0, lat);
        flush_on_fill = 1'b0; mem_data = 32'hbbbbbbbb;
        xfer("no fill", 32'h30000040, 1'b0, 32'h0, 4'hf, 1'b0, 32'hbbbbbbbb, 1'b0, lat);
        chk("no fill miss", miss_cnt, 32'd10);

        mem_data = 32'hcccccccc;
        xfer("fill60", 32'h30000060, 1'b0, 32'h0, 4'hf, 1'b0, 32'hcccccccc, 1'b0, lat);
        ds_lat = 1000;
        s_paddr = 32'h30000070; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        @(posedge clock); #1 s_penable = 1'b1;
        n = 0;
        while (!m_penable && n < 20) begin
            @(posedge clock); #1 n++;
        end
        chk("rst reach access", 32'(m_penable), 32'd1);
        @(negedge clock); #2 reset = 1'b1;
        #1;
        chk("rst mid psel", 32'(m_psel), 32'd0);
        chk("rst mid penable", 32'(m_penable), 32'd0);
        chk("rst mid miss", miss_cnt, 32'd0);
        s_psel = 1'b0; s_penable = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        ds_lat = 0;
        @(posedge clock); #1;
        mem_data = 32'hdddddddd; s0 = ds_setups;
        xfer("post rst", 32'h30000060, 1'b0, 32'h0, 4'hf, 1'b0, 32'hdddddddd, 1'b0, lat);
        chk("post rst setups", 32'(ds_setups - s0), 32'd1);
        chk("post rst miss", miss_cnt, 32'd1);

        mem_data = 32'h0;
        xfer("hit+flush", 32'h30000060, 1'b0, 32'h0, 4'hf, 1'b1, 32'hdddddddd, 1'b0, lat);
        chk("hit+flush cnt", hit_cnt, 32'd1);
        mem_data = 32'heeeeeeee;
        xfer("after hflush", 32'h30000060, 1'b0, 32'h0, 4'hf, 1'b0, 32'heeeeeeee, 1'b0, lat);
        chk("after hflush miss", miss_cnt, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xip_read_cache_apb.md
Name: xip_read_cache_apb

Overview:
- APB-to-APB read buffer placed directly upstream of the SPI APB bridge, between the CPU APB interconnect and the bridge.
- Holds a small direct-mapped word cache for XIP flash reads, so repeated instruction and data fetches skip the slow multi-step SPI transaction.
- Accesses outside the flash range pass through unchanged to the bridge.
- Writes into the SPI master register window flush the cache, because flash configuration may have changed.

Parameters:
- FLASH_BASE, 32'h30000000, first byte address of the XIP flash window.
- FLASH_END, 32'h3fffffff, last byte address of the XIP flash window.
- SPI_BASE, 32'h10001000, first byte address of the SPI master register window.
- SPI_END, 32'h10001fff, last byte address of the SPI master register window.
- DEPTH, 16, number of cached words; power of 2, at least 2. IDXW = log2(DEPTH); TAGW = 26 - IDXW.

Ports:
- clock, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- s_paddr, s_psel, s_penable, s_pwrite, s_pprot[2:0], s_pwdata[31:0], s_pstrb[3:0], in: upstream APB slave request.
- s_pready, s_prdata[31:0], s_pslverr, out: upstream APB slave response.
- m_paddr, m_psel, m_penable, m_pwrite, m_pprot[2:0], m_pwdata[31:0], m_pstrb[3:0], out: downstream APB master request to the bridge.
- m_pready, m_prdata[31:0], m_pslverr, in: downstream APB master response.
- flush, in, 1: synchronous single-cycle invalidate of all entries.
- hit_cnt, out, 32: count of cache hits.
- miss_cnt, out, 32: count of cache misses.

Behaviour:
- Reset (asynchronous):
  - State is IDLE; all valid bits are 0.
  - All outputs are 0, including s_pready, s_pslverr, m_psel, m_penable, m_paddr and both counters.
  - Reset mid-transaction drops the transfer: m_psel falls immediately and no fill occurs.
- Classification (in IDLE, on s_psel && s_penable):
  - flash = FLASH_BASE <= s_paddr <= FLASH_END.
  - Cache address split: word = s_paddr[27:2]; idx = word[IDXW-1:0]; tag = word[25:IDXW].
- States: IDLE, M_SETUP, M_ACCESS, RESP.
- IDLE:
  - Flash read, valid[idx] && tag match: hit.
    - Go to RESP with rdata = data[idx] and slverr = 0.
    - hit_cnt increments.
    - s_pready rises on the 2nd access-phase cycle (1-cycle hit latency).
  - Flash read, miss:
    - miss_cnt increments.
    - Latch the word-aligned address {s_paddr[31:2], 2'b00}, pwrite = 0, pprot, pstrb = 4'hf.
    - Go to M_SETUP.
  - Flash write: go to RESP with slverr = 1 and rdata = 0; no downstream access and no cache change.
  - Non-flash access: latch paddr, pwrite, pwdata, pstrb and pprot unchanged, then go to M_SETUP (passthrough).
- M_SETUP: m_psel = 1, m_penable = 0, for exactly one cycle; then go to M_ACCESS.
- M_ACCESS:
  - m_psel = 1, m_penable = 1; request signals held stable.
  - Wait on m_pready; the wait is unbounded and there is no timeout.
  - On m_pready:
    - Capture m_prdata and m_pslverr, then deassert m_psel and m_penable in the next cycle.
    - Go to RESP.
    - A flash miss with m_pslverr = 0 writes data, tag and valid=1 at idx in the same edge.
    - A flash miss with m_pslverr = 1 does not fill the entry.
- RESP:
  - s_pready = 1 for exactly one cycle, with s_prdata and s_pslverr from the captured values.
  - Then go to IDLE; s_pready, s_pslverr and s_prdata return to 0.
  - The next request is accepted no earlier than the cycle after RESP.
- Reads: full 32-bit word returned; s_pstrb is ignored; low address bits are ignored.
- Invalidation sources:
  - flush = 1 in any cycle.
  - A passthrough write with SPI_BASE <= paddr <= SPI_END, applied on its m_pready cycle.
  - Either source clears all valid bits.
- Flush in the same cycle as a fill: flush wins and the entry stays invalid.
- Flush during a hit in IDLE: the hit is still served from pre-flush data.
- Counters wrap from 32'hffffffff to 0. Passthrough and error writes do not count.

Decomposition:
- xip_cache_pkg holds:
  - State enum (IDLE, M_SETUP, M_ACCESS, RESP).
  - Default address constants.
  - IDXW/TAGW derivation functions.
- Sub-module xip_tag_array holds valid/tag/data storage. It provides:
  - Combinational lookup port (idx, tag → hit, data).
  - Write port (we, idx, tag, data).
  - flush_all, which has priority over the write port.
- The FSM and counters live in the top module.

Test Plan:
- After reset, read 0x30000010; downstream returns 0xdeadbeef:
  - Exactly one m_psel setup/access pair at m_paddr = 0x30000010.
  - s_prdata = 0xdeadbeef, miss_cnt = 1.
- Repeat read 0x30000013:
  - No m_psel activity; s_pready on the 2nd access cycle.
  - s_prdata = 0xdeadbeef, hit_cnt = 1.
- Read 0x30000050 (same idx, DEPTH = 16, different tag) → miss and refill; then read 0x30000010 → miss again; miss_cnt = 3.
- Write 0x10001004 = 0x03000000 → forwarded with m_pwrite = 1, m_pwdata = 0x03000000 and original pstrb; next read 0x30000050 misses.
- Write 0x30000000 → s_pslverr = 1 with s_pready, no downstream transfer; a flash read with m_pslverr = 1 gives s_pslverr = 1 and a follow-up read misses.
- Assert reset during M_ACCESS → m_psel = 0 immediately; after release, the earlier address misses; flush coincident with fill leaves the entry invalid.
